mmio_uart_responder: RTL and testbench

Memory-mapped I/O responder that services the CPU memory stage's load/store accesses to the I/O address region and owns the board serial line. It contains an 8N1 UART transmitter and receiver, each buffered by a FIFO, plus a free-running cycle counter. It sits beside the data and BIOS memories on the memory-stage bus and returns load data with the same one-cycle latency as those block RAMs.

---
 rtl/mmio_uart_responder.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mmio_uart_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_responder.sv
// Memory-mapped UART responder: status / rx / tx / cycle-counter registers on the
// memory-stage I/O bus, with FIFO-buffered 8N1 transmitter and receiver.
module mmio_uart_responder #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_en,
  input  logic [3:0]  io_we,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_din,
  output logic [31:0] io_dout,
  input  logic        serial_in,
  output logic        serial_out
);

  localparam int BIT_PERIOD  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CW          = $clog2(BIT_PERIOD + 1);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [3:0] OFF_STATUS = 4'd0;
  localparam logic [3:0] OFF_RXDATA = 4'd1;
  localparam logic [3:0] OFF_TXDATA = 4'd2;
  localparam logic [3:0] OFF_CYCLE  = 4'd4;
  localparam logic [3:0] OFF_CLEAR  = 4'd6;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} uart_state_t;

  logic [3:0]  off_s;
  logic        load_s, store_s, status_rd_s;
  logic [31:0] rd_data_s, cycle_r;
  logic        overrun_r, serial_out_r;
  logic        addr_unused_s;

  assign off_s         = io_addr[5:2];
  assign load_s        = io_en & (io_we == 4'd0);
  assign store_s       = io_en & (io_we != 4'd0);
  assign status_rd_s   = load_s & (off_s == OFF_STATUS);
  assign addr_unused_s = ^{io_addr[31:6], io_addr[1:0], io_din[31:8]};
  assign serial_out    = serial_out_r;

  // ---------------- TX FIFO ----------------
  logic [7:0]  tx_mem_r [FIFO_DEPTH];
  logic [AW:0] tx_wr_r, tx_rd_r;
  logic        tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;

  assign tx_full_s  = (tx_wr_r[AW-1:0] == tx_rd_r[AW-1:0]) && (tx_wr_r[AW] != tx_rd_r[AW]);
  assign tx_empty_s = (tx_wr_r == tx_rd_r);
  assign tx_push_s  = store_s && (off_s == OFF_TXDATA) && !tx_full_s;

  // TX FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_r <= '0;
      tx_rd_r <= '0;
    end else begin
      if (tx_push_s) tx_wr_r <= tx_wr_r + 1'b1;
      if (tx_pop_s)  tx_rd_r <= tx_rd_r + 1'b1;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wr_r[AW-1:0]] <= io_din[7:0];
  end

  // ---------------- TX FSM ----------------
  uart_state_t tx_state_r, tx_next_s;
  logic [CW-1:0] tx_baud_r;
  logic [2:0]    tx_bit_r;
  logic [7:0]    tx_shift_r;
  logic          tx_tick_s, tx_line_s;

  assign tx_tick_s = (tx_baud_r == BIT_LAST);

  // TX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state_r <= S_IDLE;
    else     tx_state_r <= tx_next_s;
  end

  // TX next state; a finished stop bit chains straight into the next start bit
  always_comb begin
    tx_next_s = tx_state_r;
    tx_pop_s  = 1'b0;
    case (tx_state_r)
      S_IDLE: begin
        if (!tx_empty_s) begin
          tx_next_s = S_START;
          tx_pop_s  = 1'b1;
        end else begin
          tx_next_s = S_IDLE;
        end
      end
      S_START: begin
        if (tx_tick_s) tx_next_s = S_DATA;
        else           tx_next_s = S_START;
      end
      S_DATA: begin
        if (tx_tick_s && (tx_bit_r == 3'd7)) tx_next_s = S_STOP;
        else                                 tx_next_s = S_DATA;
      end
      S_STOP: begin
        if (tx_tick_s && !tx_empty_s) begin
          tx_next_s = S_START;
          tx_pop_s  = 1'b1;
        end else if (tx_tick_s) begin
          tx_next_s = S_IDLE;
        end else begin
          tx_next_s = S_STOP;
        end
      end
      default: tx_next_s = S_IDLE;
    endcase
  end

  // TX line level for the current state
  always_comb begin
    tx_line_s = 1'b1;
    case (tx_state_r)
      S_IDLE:  tx_line_s = 1'b1;
      S_START: tx_line_s = 1'b0;
      S_DATA:  tx_line_s = tx_shift_r[tx_bit_r];
      S_STOP:  tx_line_s = 1'b1;
      default: tx_line_s = 1'b1;
    endcase
  end

  // TX baud timer, bit index, shift register and registered line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_baud_r    <= '0;
      tx_bit_r     <= 3'd0;
      tx_shift_r   <= 8'd0;
      serial_out_r <= 1'b1;
    end else begin
      if ((tx_state_r == S_IDLE) || tx_tick_s) tx_baud_r <= '0;
      else                                     tx_baud_r <= tx_baud_r + CW'(1);
      if ((tx_state_r == S_DATA) && tx_tick_s) tx_bit_r <= tx_bit_r + 3'd1;
      if (tx_pop_s) tx_shift_r <= tx_mem_r[tx_rd_r[AW-1:0]];
      serial_out_r <= tx_line_s;
    end
  end

  // ---------------- RX FSM ----------------
  uart_state_t rx_state_r, rx_next_s;
  logic          rx_sync1_r, rx_sync2_r, rx_prev_r;
  logic [CW-1:0] rx_baud_r;
  logic [2:0]    rx_bit_r;
  logic [7:0]    rx_shift_r;
  logic          rx_fall_s, rx_tick_s, rx_push_s, rx_shift_en_s;

  assign rx_fall_s = rx_prev_r & ~rx_sync2_r;
  assign rx_tick_s = (rx_state_r == S_START) ? (rx_baud_r == HALF_LAST) : (rx_baud_r == BIT_LAST);

  // RX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_r <= S_IDLE;
    else     rx_state_r <= rx_next_s;
  end

  // RX next state; a high line at mid-start is a false start
  always_comb begin
    rx_next_s = rx_state_r;
    case (rx_state_r)
      S_IDLE: begin
        if (rx_fall_s) rx_next_s = S_START;
        else           rx_next_s = S_IDLE;
      end
      S_START: begin
        if (rx_tick_s && rx_sync2_r) rx_next_s = S_IDLE;
        else if (rx_tick_s)          rx_next_s = S_DATA;
        else                         rx_next_s = S_START;
      end
      S_DATA: begin
        if (rx_tick_s && (rx_bit_r == 3'd7)) rx_next_s = S_STOP;
        else                                 rx_next_s = S_DATA;
      end
      S_STOP: begin
        if (rx_tick_s) rx_next_s = S_IDLE;
        else           rx_next_s = S_STOP;
      end
      default: rx_next_s = S_IDLE;
    endcase
  end

  // RX outputs: shift strobe at data mid-bits, push on a valid stop bit
  always_comb begin
    rx_push_s     = 1'b0;
    rx_shift_en_s = 1'b0;
    case (rx_state_r)
      S_DATA:  rx_shift_en_s = rx_tick_s;
      S_STOP:  rx_push_s     = rx_tick_s & rx_sync2_r;
      default: rx_push_s     = 1'b0;
    endcase
  end

  // RX synchronizer, baud timer, bit index and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_baud_r  <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      rx_sync1_r <= serial_in;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
      if ((rx_state_r == S_IDLE) || rx_tick_s) rx_baud_r <= '0;
      else                                     rx_baud_r <= rx_baud_r + CW'(1);
      if (rx_shift_en_s) begin
        rx_bit_r   <= rx_bit_r + 3'd1;
        rx_shift_r <= {rx_sync2_r, rx_shift_r[7:1]};
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]  rx_mem_r [FIFO_DEPTH];
  logic [AW:0] rx_wr_r, rx_rd_r;
  logic        rx_full_s, rx_empty_s, rx_pop_s, rx_wr_s, overrun_set_s;

  assign rx_full_s     = (rx_wr_r[AW-1:0] == rx_rd_r[AW-1:0]) && (rx_wr_r[AW] != rx_rd_r[AW]);
  assign rx_empty_s    = (rx_wr_r == rx_rd_r);
  assign rx_pop_s      = load_s && (off_s == OFF_RXDATA) && !rx_empty_s;
  assign rx_wr_s       = rx_push_s && !rx_full_s;
  assign overrun_set_s = rx_push_s && rx_full_s;

  // RX FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_r <= '0;
      rx_rd_r <= '0;
    end else begin
      if (rx_wr_s)  rx_wr_r <= rx_wr_r + 1'b1;
      if (rx_pop_s) rx_rd_r <= rx_rd_r + 1'b1;
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_wr_s) rx_mem_r[rx_wr_r[AW-1:0]] <= rx_shift_r;
  end

  // ---------------- registers and load path ----------------
  // Read data mux, sampled at the request edge
  always_comb begin
    rd_data_s = 32'd0;
    case (off_s)
      OFF_STATUS: rd_data_s = {29'd0, overrun_r, ~rx_empty_s, ~tx_full_s};
      OFF_RXDATA: rd_data_s = rx_empty_s ? 32'd0 : {24'd0, rx_mem_r[rx_rd_r[AW-1:0]]};
      OFF_CYCLE:  rd_data_s = cycle_r;
      default:    rd_data_s = 32'd0;
    endcase
  end

  // Sticky overrun (set wins over clear), cycle counter (clear wins), load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_r <= 1'b0;
      cycle_r   <= 32'd0;
      io_dout   <= 32'd0;
    end else begin
      if (overrun_set_s)    overrun_r <= 1'b1;
      else if (status_rd_s) overrun_r <= 1'b0;
      if (store_s && (off_s == OFF_CLEAR)) cycle_r <= 32'd0;
      else                                 cycle_r <= cycle_r + 32'd1;
      if (load_s) io_dout <= rd_data_s;
    end
  end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Scoreboard bench for mmio_uart_responder: loads queue expected io_dout values that a
// monitor checks; a line monitor decodes serial_out frames.
module tb_mmio_uart_responder;

  localparam int BP = 16;  // 1_000_000 / 60_000 = 16.67, truncated

  logic        clk, rst, io_en, serial_in, serial_out;
  logic [3:0]  io_we;
  logic [31:0] io_addr, io_din, io_dout;

  mmio_uart_responder #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(60_000), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_din(io_din),
    .io_dout(io_dout), .serial_in(serial_in), .serial_out(serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard of expected load data
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  initial forever begin
    @(posedge clk);
    if (io_en === 1'b1 && io_we === 4'd0) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_load: got 0x%08h, expected no load", io_dout);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, io_dout, mon_exp);
      end
    end
  end

  // serial_out frame decoder
  typedef struct {
    logic [7:0] data;
    logic       stop;
    longint     start;
  } frame_t;
  frame_t tx_q[$];
  frame_t fr;

  initial forever begin
    @(negedge clk);
    if (rst === 1'b0 && serial_out === 1'b0) begin
      fr.start = cyc;
      fr.data  = 8'd0;
      repeat (BP / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BP) @(negedge clk);
        fr.data[i] = serial_out;
      end
      repeat (BP) @(negedge clk);
      fr.stop = serial_out;
      tx_q.push_back(fr);
    end
  end

  // bus access tasks: called at a negedge, return at the negedge after the request edge
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    io_en = 1'b1; io_we = 4'd0; io_addr = addr;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    io_en = 1'b0; io_addr = 32'd0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    io_en = 1'b1; io_we = 4'hF; io_addr = addr; io_din = data;
    @(negedge clk);
    io_en = 1'b0; io_we = 4'd0; io_addr = 32'd0; io_din = 32'd0;
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    repeat (BP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (BP) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (BP) @(negedge clk);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int b;
    b = budget;
    while (tx_q.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    check(name, 32'(tx_q.size()), 32'(n));
  endtask

  logic [7:0] tx_bytes [0:8] = '{8'h01, 8'h80, 8'hC3, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h77};
  logic [7:0] rx_bytes [0:8] = '{8'h11, 8'h22, 8'h48, 8'h81, 8'h7E, 8'hE7, 8'h00, 8'hFF, 8'h99};
  logic [7:0] exp_frame;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; io_en = 1'b0; io_we = 4'd0; io_addr = 32'd0; io_din = 32'd0; serial_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_serial_out", {31'd0, serial_out}, 32'd1);
    check("reset_io_dout", io_dout, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd(32'h0000_0000, 32'h0000_0001, "status_after_reset");
    rd(32'hFFFF_FFC0, 32'h0000_0001, "status_high_addr_bits_ignored");
    rd(32'h0000_000C, 32'h0000_0000, "unmapped_read");

    // TX: start bit two edges after the write, then 8 more bytes fill the FIFO
    wr(32'h0000_0008, 32'hFFFF_FF55);
    check("tx_line_after_edge_n", {31'd0, serial_out}, 32'd1);
    @(negedge clk);
    check("tx_line_after_edge_n1", {31'd0, serial_out}, 32'd1);
    @(negedge clk);
    check("tx_start_after_edge_n2", {31'd0, serial_out}, 32'd0);
    for (int i = 0; i < 9; i++) wr(32'h0000_0008, {24'd0, tx_bytes[i]});
    rd(32'h0000_0000, 32'h0000_0000, "status_tx_full");
    wait_frames(9, 12 * 10 * BP, "tx_frame_count");
    for (int i = 0; i < 9; i++) begin
      if (i < tx_q.size()) begin
        exp_frame = (i == 0) ? 8'h55 : tx_bytes[i-1];
        check($sformatf("tx_frame%0d_data", i), {24'd0, tx_q[i].data}, {24'd0, exp_frame});
        check($sformatf("tx_frame%0d_stop", i), {31'd0, tx_q[i].stop}, 32'd1);
        if (i > 0)
          check($sformatf("tx_frame%0d_spacing", i), 32'(tx_q[i].start - tx_q[i-1].start), 32'(10 * BP));
      end
    end
    repeat (2 * 10 * BP) @(negedge clk);
    check("tx_dropped_ninth_byte", 32'(tx_q.size()), 32'd9);
    rd(32'h0000_0000, 32'h0000_0001, "status_tx_drained");
    tx_q.delete();

    // RX: single byte, empty read, false start, framing error
    send_serial(8'hA3, 1'b1);
    rd(32'h0000_0000, 32'h0000_0003, "status_rx_valid");
    rd(32'h0000_0004, 32'h0000_00A3, "rx_data_a3");
    rd(32'h0000_0000, 32'h0000_0001, "status_rx_popped");
    rd(32'h0000_0004, 32'h0000_0000, "rx_read_empty");
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (3 * BP) @(negedge clk);
    send_serial(8'h5A, 1'b0);
    rd(32'h0000_0000, 32'h0000_0001, "status_false_start_framing");

    // RX overrun: nine frames without reading
    for (int i = 0; i < 9; i++) send_serial(rx_bytes[i], 1'b1);
    rd(32'h0000_0000, 32'h0000_0007, "status_overrun");
    for (int i = 0; i < 8; i++) rd(32'h0000_0004, {24'd0, rx_bytes[i]}, $sformatf("rx_fifo_byte%0d", i));
    rd(32'h0000_0000, 32'h0000_0001, "status_overrun_cleared");
    rd(32'h0000_0004, 32'h0000_0000, "rx_read_after_drain");

    // cycle counter: clear at edge N, read at N+10 and N+11, store leaves io_dout alone
    wr(32'h0000_0018, 32'hDEAD_BEEF);
    repeat (9) @(negedge clk);
    rd(32'h0000_0010, 32'd9, "counter_after_clear");
    rd(32'h0000_0010, 32'd10, "counter_next_cycle");
    wr(32'h0000_0010, 32'h1234_5678);
    check("store_keeps_io_dout", io_dout, 32'd10);

    // reset mid-frame with a queued byte and a partial RX start bit
    wr(32'h0000_0008, 32'h0000_0000);
    wr(32'h0000_0008, 32'h0000_00F0);
    repeat (3 * BP) @(negedge clk);
    check("tx_low_before_rst", {31'd0, serial_out}, 32'd0);
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    serial_in = 1'b1;
    @(negedge clk);
    check("rst_forces_serial_out", {31'd0, serial_out}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rd(32'h0000_0000, 32'h0000_0001, "status_after_midframe_rst");
    repeat (12 * BP) @(negedge clk);
    tx_q.delete();
    repeat (12 * BP) @(negedge clk);
    check("no_tx_after_rst", 32'(tx_q.size()), 32'd0);
    rd(32'h0000_0000, 32'h0000_0001, "status_final");

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
